// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM state codes, letter codes, element timing and the A..Z keying table.
package morse_pkg;

    localparam int unsigned LETTER_W     = 5;
    localparam int unsigned LEN_W        = 3;
    localparam int unsigned PAT_W        = 4;
    localparam int unsigned IDX_W        = 2;
    localparam int unsigned UNITS_W      = 2;
    localparam int unsigned LETTER_COUNT = 26;

    localparam int unsigned DOT_UNITS        = 1;
    localparam int unsigned DASH_UNITS       = 3;
    localparam int unsigned ELEM_GAP_UNITS   = 1;
    localparam int unsigned LETTER_GAP_UNITS = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_MARK  = 2'b01,
        ST_SPACE = 2'b10,
        ST_LGAP  = 2'b11
    } state_t;

    // len = element count 1..4; pat is MSB-first, 1 = dash, unused low bits are 0
    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [PAT_W-1:0] pat;
    } morse_code_t;

    localparam logic [LETTER_W-1:0] LTR_A = 5'd0;
    localparam logic [LETTER_W-1:0] LTR_B = 5'd1;
    localparam logic [LETTER_W-1:0] LTR_C = 5'd2;
    localparam logic [LETTER_W-1:0] LTR_D = 5'd3;
    localparam logic [LETTER_W-1:0] LTR_E = 5'd4;
    localparam logic [LETTER_W-1:0] LTR_F = 5'd5;
    localparam logic [LETTER_W-1:0] LTR_G = 5'd6;
    localparam logic [LETTER_W-1:0] LTR_H = 5'd7;
    localparam logic [LETTER_W-1:0] LTR_I = 5'd8;
    localparam logic [LETTER_W-1:0] LTR_J = 5'd9;
    localparam logic [LETTER_W-1:0] LTR_K = 5'd10;
    localparam logic [LETTER_W-1:0] LTR_L = 5'd11;
    localparam logic [LETTER_W-1:0] LTR_M = 5'd12;
    localparam logic [LETTER_W-1:0] LTR_N = 5'd13;
    localparam logic [LETTER_W-1:0] LTR_O = 5'd14;
    localparam logic [LETTER_W-1:0] LTR_P = 5'd15;
    localparam logic [LETTER_W-1:0] LTR_Q = 5'd16;
    localparam logic [LETTER_W-1:0] LTR_R = 5'd17;
    localparam logic [LETTER_W-1:0] LTR_S = 5'd18;
    localparam logic [LETTER_W-1:0] LTR_T = 5'd19;
    localparam logic [LETTER_W-1:0] LTR_U = 5'd20;
    localparam logic [LETTER_W-1:0] LTR_V = 5'd21;
    localparam logic [LETTER_W-1:0] LTR_W = 5'd22;
    localparam logic [LETTER_W-1:0] LTR_X = 5'd23;
    localparam logic [LETTER_W-1:0] LTR_Y = 5'd24;
    localparam logic [LETTER_W-1:0] LTR_Z = 5'd25;

    function automatic morse_code_t morse_lookup(input logic [LETTER_W-1:0] code);
        morse_code_t res;
        res = '0;
        case (code)
            LTR_A: res = '{len: 3'd2, pat: 4'b0100};
            LTR_B: res = '{len: 3'd4, pat: 4'b1000};
            LTR_C: res = '{len: 3'd4, pat: 4'b1010};
            LTR_D: res = '{len: 3'd3, pat: 4'b1000};
            LTR_E: res = '{len: 3'd1, pat: 4'b0000};
            LTR_F: res = '{len: 3'd4, pat: 4'b0010};
            LTR_G: res = '{len: 3'd3, pat: 4'b1100};
            LTR_H: res = '{len: 3'd4, pat: 4'b0000};
            LTR_I: res = '{len: 3'd2, pat: 4'b0000};
            LTR_J: res = '{len: 3'd4, pat: 4'b0111};
            LTR_K: res = '{len: 3'd3, pat: 4'b1010};
            LTR_L: res = '{len: 3'd4, pat: 4'b0100};
            LTR_M: res = '{len: 3'd2, pat: 4'b1100};
            LTR_N: res = '{len: 3'd2, pat: 4'b1000};
            LTR_O: res = '{len: 3'd3, pat: 4'b1110};
            LTR_P: res = '{len: 3'd4, pat: 4'b0110};
            LTR_Q: res = '{len: 3'd4, pat: 4'b1101};
            LTR_R: res = '{len: 3'd3, pat: 4'b0100};
            LTR_S: res = '{len: 3'd3, pat: 4'b0000};
            LTR_T: res = '{len: 3'd1, pat: 4'b1000};
            LTR_U: res = '{len: 3'd3, pat: 4'b0010};
            LTR_V: res = '{len: 3'd4, pat: 4'b0001};
            LTR_W: res = '{len: 3'd3, pat: 4'b0110};
            LTR_X: res = '{len: 3'd4, pat: 4'b1001};
            LTR_Y: res = '{len: 3'd4, pat: 4'b1011};
            LTR_Z: res = '{len: 3'd4, pat: 4'b1100};
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/morse_unit_tick.sv
// Morse unit divider: free-running 0..UNIT_CYCLES-1 counter with synchronous clear and a
// combinational tick in the last cycle of each unit.
module morse_unit_tick #(
    parameter int unsigned UNIT_CYCLES = 5000000
) (
    input  logic clock50,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick_c
);

    localparam int unsigned CNT_W = (UNIT_CYCLES > 2) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UNIT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    assign tick_c = (count == CNT_LAST);

    always_ff @(posedge clock50 or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick_c ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/morse_tx.sv
// Morse transmitter: accepts one letter code per start/busy handshake and keys it out on tx
// with unit-based mark, element-gap and letter-gap timing.
module morse_tx
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 5000000
) (
    input  logic                clock50,
    input  logic                reset,
    input  logic                start,
    input  logic [LETTER_W-1:0] letter,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                tx,
    output logic [1:0]          state_led
);

    state_t              state, state_n;
    logic [LEN_W-1:0]    len_q, len_n;
    logic [PAT_W-1:0]    pat_q, pat_n;
    logic [IDX_W-1:0]    idx_q, idx_n;
    logic [UNITS_W-1:0]  units_q, units_n;
    logic                tx_n, busy_n, done_n, err_n;

    logic                accept_c;
    logic                tick_c;
    morse_code_t         code_c;
    logic [PAT_W-1:0]    pat_sh_c;
    logic [UNITS_W-1:0]  mark_last_c;
    logic                last_elem_c;

    morse_unit_tick #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_tick (
        .clock50(clock50),
        .reset  (reset),
        .clear  (accept_c),
        .enable (state != ST_IDLE),
        .tick_c (tick_c)
    );

    // Current element sits in the MSB of the pattern shifted by the element index
    assign pat_sh_c    = pat_q << idx_q;
    assign mark_last_c = pat_sh_c[PAT_W-1] ? UNITS_W'(DASH_UNITS - 1) : UNITS_W'(DOT_UNITS - 1);
    assign last_elem_c = (LEN_W'(idx_q) >= (len_q - LEN_W'(1)));
    assign state_led   = state;

    always_comb begin
        state_n  = state;
        len_n    = len_q;
        pat_n    = pat_q;
        idx_n    = idx_q;
        units_n  = units_q;
        accept_c = 1'b0;
        done_n   = 1'b0;
        err_n    = 1'b0;
        code_c   = morse_lookup(letter);

        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (letter < LETTER_W'(LETTER_COUNT)) begin
                        accept_c = 1'b1;
                        len_n    = code_c.len;
                        pat_n    = code_c.pat;
                        idx_n    = '0;
                        units_n  = '0;
                        state_n  = ST_MARK;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ST_MARK: begin
                if (tick_c) begin
                    if (units_q == mark_last_c) begin
                        units_n = '0;
                        state_n = last_elem_c ? ST_LGAP : ST_SPACE;
                    end else begin
                        units_n = units_q + UNITS_W'(1);
                    end
                end
            end
            ST_SPACE: begin
                if (tick_c) begin
                    if (units_q == UNITS_W'(ELEM_GAP_UNITS - 1)) begin
                        units_n = '0;
                        idx_n   = idx_q + IDX_W'(1);
                        state_n = ST_MARK;
                    end else begin
                        units_n = units_q + UNITS_W'(1);
                    end
                end
            end
            ST_LGAP: begin
                if (tick_c) begin
                    if (units_q == UNITS_W'(LETTER_GAP_UNITS - 1)) begin
                        units_n = '0;
                        done_n  = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        units_n = units_q + UNITS_W'(1);
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        tx_n   = (state_n == ST_MARK);
        busy_n = (state_n != ST_IDLE);
    end

    always_ff @(posedge clock50 or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            len_q   <= '0;
            pat_q   <= '0;
            idx_q   <= '0;
            units_q <= '0;
            tx      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            len_q   <= len_n;
            pat_q   <= pat_n;
            idx_q   <= idx_n;
            units_q <= units_n;
            tx      <= tx_n;
            busy    <= busy_n;
            done    <= done_n;
            err     <= err_n;
        end
    end

endmodule

// File: tb/tb_morse_tx.sv
// Bench for morse_tx: per-cycle comparison against a queue-based keying model built from
// dot/dash strings, plus directed letter, error, ignore and reset scenarios.
module tb_morse_tx;

    localparam int unsigned UC = 4;

    logic       clock50 = 1'b0;
    logic       reset   = 1'b1;
    logic       start   = 1'b0;
    logic [4:0] letter  = 5'd0;
    logic       busy, done, err, tx;
    logic [1:0] state_led;

    int n_cmp = 0;
    int n_bad = 0;
    bit run_chk = 1'b0;

    morse_tx #(.UNIT_CYCLES(UC)) dut (
        .clock50  (clock50),
        .reset    (reset),
        .start    (start),
        .letter   (letter),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .tx       (tx),
        .state_led(state_led)
    );

    always #5 clock50 = ~clock50;

    string morse_str [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                              ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                              "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

    // Per-cycle expected state codes: 1 = key on, 2 = element gap, 3 = letter gap
    logic [1:0] seq [$];

    task automatic make_seq(input int l);
        string s;
        int    n;
        seq.delete();
        s = morse_str[l];
        for (int i = 0; i < s.len(); i++) begin
            n = (s[i] == "-") ? 3 : 1;
            repeat (n * UC) seq.push_back(2'd1);
            if (i < s.len() - 1) repeat (UC) seq.push_back(2'd2);
        end
        repeat (3 * UC) seq.push_back(2'd3);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model
    logic [1:0] q [$];
    bit         in_flight = 1'b0;
    logic       exp_tx = 1'b0, exp_busy = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
    logic [1:0] exp_state = 2'd0;

    initial begin
        forever begin
            @(posedge clock50 or negedge reset);
            if (!reset) begin
                q.delete();
                in_flight = 1'b0;
                exp_state = 2'd0;
                exp_done  = 1'b0;
                exp_err   = 1'b0;
            end else begin
                exp_done = 1'b0;
                exp_err  = 1'b0;
                if (in_flight && q.size() == 0) begin
                    in_flight = 1'b0;
                    exp_done  = 1'b1;
                    exp_state = 2'd0;
                end else if (in_flight) begin
                    exp_state = q.pop_front();
                end else if (start && letter <= 5'd25) begin
                    make_seq(int'(letter));
                    q = seq;
                    in_flight = 1'b1;
                    exp_state = q.pop_front();
                end else begin
                    exp_state = 2'd0;
                    exp_err   = start && (letter > 5'd25);
                end
            end
            exp_tx   = (exp_state == 2'd1);
            exp_busy = (exp_state != 2'd0);
        end
    end

    // Every-cycle compare of all outputs against the model
    initial begin
        logic [5:0] got, want;
        forever begin
            @(negedge clock50);
            if (run_chk) begin
                got  = {tx, busy, done, err, state_led};
                want = {exp_tx, exp_busy, exp_done, exp_err, exp_state};
                n_cmp++;
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL cycle {tx,busy,done,err,state}: got %b expected %b at %0t",
                             got, want, $time);
                end
            end
        end
    end

    task automatic send(input logic [4:0] l, input int poke,
                        output int nb, output int nt, output int nd);
        nb = 0; nt = 0; nd = 0;
        @(negedge clock50);
        start  = 1'b1;
        letter = l;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock50);
            start = (c == poke);
            if (c == poke) letter = 5'd1;
            nb += int'(busy);
            nt += int'(tx);
            nd += int'(done);
        end
        start = 1'b0;
    endtask

    initial begin
        int nb, nt, nd, ones;

        // Pin the model against hand-derived lengths
        make_seq(4);
        check("model_E_len", seq.size(), 16);
        make_seq(16);
        ones = 0;
        foreach (seq[i]) ones += (seq[i] == 2'd1) ? 1 : 0;
        check("model_Q_len", seq.size(), 64);
        check("model_Q_on", ones, 40);

        #1 reset = 1'b0;
        #1 run_chk = 1'b1;
        repeat (3) @(negedge clock50);
        check("reset_busy", int'(busy), 0);
        check("reset_tx", int'(tx), 0);
        check("reset_state", int'(state_led), 0);
        reset = 1'b1;
        repeat (2) @(negedge clock50);

        send(5'd4, -1, nb, nt, nd);
        check("E_busy", nb, 16);
        check("E_tx", nt, 4);
        check("E_done", nd, 1);

        send(5'd0, 10, nb, nt, nd);
        check("A_busy", nb, 32);
        check("A_tx", nt, 16);
        check("A_done", nd, 1);

        send(5'd16, -1, nb, nt, nd);
        check("Q_busy", nb, 64);
        check("Q_tx", nt, 40);
        check("Q_done", nd, 1);

        @(negedge clock50);
        start = 1'b1; letter = 5'd30;
        @(negedge clock50);
        start = 1'b0;
        check("bad_err", int'(err), 1);
        check("bad_busy", int'(busy), 0);
        check("bad_tx", int'(tx), 0);
        check("bad_state", int'(state_led), 0);
        @(negedge clock50);
        check("bad_err_clr", int'(err), 0);

        // Reset in the middle of the T dash
        @(negedge clock50);
        start = 1'b1; letter = 5'd19;
        @(negedge clock50);
        start = 1'b0;
        repeat (4) @(negedge clock50);
        check("T_tx_before", int'(tx), 1);
        #3 reset = 1'b0;
        #1;
        check("rst_async_tx", int'(tx), 0);
        check("rst_async_busy", int'(busy), 0);
        check("rst_async_state", int'(state_led), 0);
        nd = 0;
        repeat (5) begin
            @(negedge clock50);
            nd += int'(done);
        end
        check("rst_no_done", nd, 0);
        reset = 1'b1;
        @(negedge clock50);

        send(5'd4, -1, nb, nt, nd);
        check("E2_busy", nb, 16);
        check("E2_tx", nt, 4);
        check("E2_done", nd, 1);

        // Random starts, letters and occasional resets
        for (int i = 0; i < 1500; i++) begin
            @(negedge clock50);
            start  = ($urandom_range(0, 3) == 0);
            letter = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b0;
                @(negedge clock50);
                reset = 1'b1;
            end
        end

        // Start held high: back-to-back re-trigger with changing letters
        for (int i = 0; i < 400; i++) begin
            @(negedge clock50);
            start  = 1'b1;
            letter = 5'($urandom_range(0, 25));
        end
        start = 1'b0;
        repeat (80) @(negedge clock50);

        run_chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
